// File: rtl/data_memory.sv
// data_memory
//   Word-organised, little-endian data memory with RISC-V load/store
//   formatting for the single-cycle datapath. Stores commit on the rising
//   clock edge; loads, alignment and fault flags are combinational from the
//   current inputs and memory contents.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       width of Address
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset; clears every word
//   Address      byte address from the ALU result
//   WriteData    store data (register-file read port 2)
//   MemWrite     store enable
//   MemRead      load enable
//   Funct3       size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   DataMemRead  formatted load data, 0 when no valid load
//   Misaligned   active access not naturally aligned for its size
//   AccessFault  active access out of range or with an illegal Funct3
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [2:0]        Funct3,
  output logic [31:0]       DataMemRead,
  output logic              Misaligned,
  output logic              AccessFault
);

  localparam int IW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [IW-1:0] word_idx;
  logic [1:0]    lane;
  logic          active;
  logic          in_range;
  logic          illegal_f3;
  logic          mis_raw;
  logic          load_ok;
  logic          store_ok;
  logic [3:0]    byte_en;
  logic [31:0]   store_data;
  logic [31:0]   rd_word;

  // Select and extend the addressed byte/halfword of a word.
  function automatic logic [31:0] format_load(input logic [31:0] w,
                                              input logic [1:0]  ln,
                                              input logic [2:0]  f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{ln, 3'b000} +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = 32'(b);           // LB: sign-extend
      3'b001:  r = 32'(h);           // LH: sign-extend
      3'b010:  r = w;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign word_idx = Address[IW+1:2];
  assign lane     = Address[1:0];
  assign active   = MemRead | MemWrite;
  // Any set bit above the word index means out of range; no aliasing.
  assign in_range = (Address >> (IW + 2)) == '0;
  assign rd_word  = mem[word_idx];

  always_comb begin
    illegal_f3 = (Funct3 == 3'b011) || (Funct3 == 3'b110) || (Funct3 == 3'b111);
    mis_raw    = 1'b0;
    if ((Funct3 == 3'b001 || Funct3 == 3'b101) && Address[0])
      mis_raw = 1'b1;
    if (Funct3 == 3'b010 && lane != 2'b00)
      mis_raw = 1'b1;
  end

  // Flags are forced low while reset is held so all outputs read zero.
  assign Misaligned  = rst_n & active & mis_raw;
  assign AccessFault = rst_n & active & (~in_range | illegal_f3);
  assign load_ok     = rst_n & MemRead & ~Misaligned & ~AccessFault;
  assign store_ok    = MemWrite & ~Misaligned & ~AccessFault;
  assign DataMemRead = load_ok ? format_load(rd_word, lane, Funct3) : 32'd0;

  // Replicate store data across lanes so each enabled lane picks its byte.
  always_comb begin
    byte_en    = 4'b0000;
    store_data = WriteData;
    case (Funct3)
      3'b000: begin
        byte_en    = 4'b0001 << lane;
        store_data = {4{WriteData[7:0]}};
      end
      3'b001: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{WriteData[15:0]}};
      end
      3'b010: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= 32'd0;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++)
        if (byte_en[i])
          mem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  Funct3;
  logic [31:0] DataMemRead;
  logic        Misaligned;
  logic        AccessFault;

  int checks = 0;
  int errors = 0;

  data_memory #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .Funct3(Funct3),
    .DataMemRead(DataMemRead),
    .Misaligned(Misaligned),
    .AccessFault(AccessFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store committed on the next rising edge, inputs idle afterwards.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    Address = a; WriteData = d; Funct3 = f3; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Present a load; outputs settle #1 after the falling edge.
  task automatic set_load(input logic [31:0] a, input logic [2:0] f3);
    @(negedge clk);
    Address = a; Funct3 = f3; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Address = 32'h401; WriteData = 32'hFFFFFFFF; Funct3 = 3'b010;
    MemWrite = 1'b1; MemRead = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({DataMemRead, Misaligned, AccessFault} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b expected 0/0/0", DataMemRead, Misaligned, AccessFault);
    end
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    rst_n = 1'b1;
    set_load(32'h0, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL reset_lw_000: got %h expected 00000000", DataMemRead);
    end
    checks++;
    if (Misaligned !== 1'b0 || AccessFault !== 1'b0) begin
      errors++; $display("FAIL reset_flags_000: got %b%b expected 00", Misaligned, AccessFault);
    end
    set_load(32'h3FC, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL reset_lw_3fc: got %h expected 00000000", DataMemRead);
    end
    checks++;
    if (Misaligned !== 1'b0 || AccessFault !== 1'b0) begin
      errors++; $display("FAIL reset_flags_3fc: got %b%b expected 00", Misaligned, AccessFault);
    end
    go_idle();
  endtask

  task automatic test_sizes();
    do_store(32'h10, 32'h80F1A2B3, 3'b010);
    set_load(32'h10, 3'b010);
    checks++;
    if (DataMemRead !== 32'h80F1A2B3) begin
      errors++; $display("FAIL lw_10: got %h expected 80F1A2B3", DataMemRead);
    end
    set_load(32'h13, 3'b000);
    checks++;
    if (DataMemRead !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_13: got %h expected FFFFFF80", DataMemRead);
    end
    set_load(32'h13, 3'b100);
    checks++;
    if (DataMemRead !== 32'h00000080) begin
      errors++; $display("FAIL lbu_13: got %h expected 00000080", DataMemRead);
    end
    set_load(32'h12, 3'b001);
    checks++;
    if (DataMemRead !== 32'hFFFF80F1) begin
      errors++; $display("FAIL lh_12: got %h expected FFFF80F1", DataMemRead);
    end
    set_load(32'h10, 3'b101);
    checks++;
    if (DataMemRead !== 32'h0000A2B3) begin
      errors++; $display("FAIL lhu_10: got %h expected 0000A2B3", DataMemRead);
    end
    set_load(32'h11, 3'b000);
    checks++;
    if (DataMemRead !== 32'hFFFFFFA2) begin
      errors++; $display("FAIL lb_11: got %h expected FFFFFFA2", DataMemRead);
    end
    go_idle();
  endtask

  task automatic test_partial();
    do_store(32'h11, 32'hABCDEF55, 3'b000);
    set_load(32'h10, 3'b010);
    checks++;
    if (DataMemRead !== 32'h80F155B3) begin
      errors++; $display("FAIL sb_preserve: got %h expected 80F155B3", DataMemRead);
    end
    do_store(32'h12, 32'h99991234, 3'b001);
    set_load(32'h10, 3'b010);
    checks++;
    if (DataMemRead !== 32'h123455B3) begin
      errors++; $display("FAIL sh_preserve: got %h expected 123455B3", DataMemRead);
    end
    go_idle();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    Address = 32'h22; WriteData = 32'hDEADBEEF; Funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b0;
    #1;
    checks++;
    if (Misaligned !== 1'b1) begin
      errors++; $display("FAIL sw_22_mis: got %b expected 1", Misaligned);
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    set_load(32'h20, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL sw_22_nowrite: got %h expected 00000000", DataMemRead);
    end
    set_load(32'h21, 3'b001);
    checks++;
    if (Misaligned !== 1'b1 || DataMemRead !== 32'h0) begin
      errors++; $display("FAIL lh_21: got mis=%b data=%h expected mis=1 data=00000000", Misaligned, DataMemRead);
    end
    set_load(32'h21, 3'b000);
    checks++;
    if (Misaligned !== 1'b0) begin
      errors++; $display("FAIL lb_21_mis: got %b expected 0", Misaligned);
    end
    set_load(32'h11, 3'b101);
    checks++;
    if (Misaligned !== 1'b1 || DataMemRead !== 32'h0) begin
      errors++; $display("FAIL lhu_11: got mis=%b data=%h expected mis=1 data=00000000", Misaligned, DataMemRead);
    end
    @(negedge clk);
    MemRead = 1'b0; Address = 32'h23; Funct3 = 3'b010;
    #1;
    checks++;
    if (Misaligned !== 1'b0) begin
      errors++; $display("FAIL idle_mis: got %b expected 0", Misaligned);
    end
  endtask

  task automatic test_faults();
    @(negedge clk);
    Address = 32'h400; WriteData = 32'hFFFFFFFF; Funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b0;
    #1;
    checks++;
    if (AccessFault !== 1'b1) begin
      errors++; $display("FAIL sw_400_fault: got %b expected 1", AccessFault);
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    set_load(32'h0, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL sw_400_noalias: got %h expected 00000000", DataMemRead);
    end
    set_load(32'h10, 3'b011);
    checks++;
    if (AccessFault !== 1'b1 || DataMemRead !== 32'h0) begin
      errors++; $display("FAIL f3_011: got fault=%b data=%h expected fault=1 data=00000000", AccessFault, DataMemRead);
    end
    set_load(32'h80000010, 3'b010);
    checks++;
    if (AccessFault !== 1'b1 || DataMemRead !== 32'h0) begin
      errors++; $display("FAIL high_addr: got fault=%b data=%h expected fault=1 data=00000000", AccessFault, DataMemRead);
    end
    set_load(32'h3FF, 3'b000);
    checks++;
    if (AccessFault !== 1'b0) begin
      errors++; $display("FAIL lb_3ff_range: got %b expected 0", AccessFault);
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'h400; Funct3 = 3'b111;
    #1;
    checks++;
    if (AccessFault !== 1'b0) begin
      errors++; $display("FAIL idle_fault: got %b expected 0", AccessFault);
    end
  endtask

  task automatic test_read_during_write();
    do_store(32'h30, 32'h11111111, 3'b010);
    @(negedge clk);
    Address = 32'h30; WriteData = 32'h22222222; Funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    checks++;
    if (DataMemRead !== 32'h11111111) begin
      errors++; $display("FAIL rdw_before: got %h expected 11111111", DataMemRead);
    end
    @(posedge clk);
    #1;
    checks++;
    if (DataMemRead !== 32'h22222222) begin
      errors++; $display("FAIL rdw_after: got %h expected 22222222", DataMemRead);
    end
    MemWrite = 1'b0;
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_store(32'h50, 32'h00000011, 3'b000);
    do_store(32'h51, 32'h00000022, 3'b000);
    do_store(32'h52, 32'h00000033, 3'b000);
    do_store(32'h53, 32'h00000044, 3'b000);
    set_load(32'h50, 3'b010);
    checks++;
    if (DataMemRead !== 32'h44332211) begin
      errors++; $display("FAIL b2b_bytes: got %h expected 44332211", DataMemRead);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    Address = 32'h40; WriteData = 32'hAAAA5555; Funct3 = 3'b010; MemWrite = 1'b1; MemRead = 1'b0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_load(32'h40, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL rst_mid_nowrite: got %h expected 00000000", DataMemRead);
    end
    set_load(32'h10, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0) begin
      errors++; $display("FAIL rst_mid_cleared: got %h expected 00000000", DataMemRead);
    end
    go_idle();
    do_store(32'h40, 32'h0BADF00D, 3'b010);
    set_load(32'h40, 3'b010);
    checks++;
    if (DataMemRead !== 32'h0BADF00D) begin
      errors++; $display("FAIL post_rst_store: got %h expected 0BADF00D", DataMemRead);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_sizes();
    test_partial();
    test_misaligned();
    test_faults();
    test_read_during_write();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
Word-organised data memory with RISC-V load/store formatting for the single-cycle datapath. It sits directly upstream of the register-write-data select stage and drives its DataMemRead input. It consumes the ALU-computed address, store data and funct3 size field. Stores commit on the rising clock edge, and loads return formatted, extended data combinationally within the same cycle.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, minimum 4.
ADDR_W, 32, width of the Address port.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
Address  input  ADDR_W  byte address from the ALU result.
WriteData  input  32  store data from register-file read port 2.
MemWrite  input  1  store enable.
MemRead  input  1  load enable.
Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
DataMemRead  output  32  formatted load data to the write-back select.
Misaligned  output  1  access not naturally aligned for its size.
AccessFault  output  1  address beyond DEPTH_WORDS, or illegal Funct3 on an active access.

Behaviour:
- Reset and storage
  - Clock is clk. Reset is rst_n: asynchronous, active-low.
  - While rst_n=0, every memory word is 0 and all outputs are 0.
  - Storage is little-endian.
  - Word index = Address[log2(DEPTH_WORDS)+1:2]. Byte lane = Address[1:0].
- Address range
  - In range: Address < 4*DEPTH_WORDS, i.e. all Address bits above log2(DEPTH_WORDS)+1 are zero.
  - No wrap-around: out-of-range addresses never alias to low words.
- Alignment
  - Misaligned=1 when (Funct3 is 001 or 101) and Address[0]=1.
  - Misaligned=1 when Funct3=010 and Address[1:0]!=0.
  - Misaligned=1 only when MemRead or MemWrite is high; otherwise 0.
- AccessFault=1 when (MemRead or MemWrite) and (out of range, or Funct3 is 011, 110 or 111).
- Outputs Misaligned, AccessFault and DataMemRead are combinational from the current inputs and memory contents (zero-cycle latency).
- Store
  - On the rising edge with MemWrite=1, rst_n=1, Misaligned=0 and AccessFault=0, update only the addressed lanes:
    - SB: WriteData[7:0] into lane Address[1:0].
    - SH: WriteData[15:0] into lanes {Address[1],0} and {Address[1],1}.
    - SW: all four lanes.
  - Unaddressed bytes are preserved.
  - A store with Misaligned=1 or AccessFault=1 writes nothing.
- Load
  - When MemRead=1 with no fault and no misalignment:
    - LB/LH sign-extend from bit 7/15 of the selected byte/halfword.
    - LBU/LHU zero-extend.
    - LW returns the full word.
  - DataMemRead=0 when MemRead=0, Misaligned=1 or AccessFault=1.
- Simultaneous events
  - MemRead and MemWrite high together to the same word: DataMemRead shows the pre-store contents during that cycle; the new contents are visible from the next cycle.
  - rst_n falling at or before a store edge: the store is lost and memory is cleared.
  - rst_n rising: the first store can commit on the next rising edge where rst_n is already 1.

Test Plan:
- Reset: hold rst_n=0 over 2 edges, release, then LW at 0x00, 0x3FC -> DataMemRead=0x00000000, Misaligned=0, AccessFault=0.
- Store/load sizes:
  - SW 0x80F1A2B3 at 0x10, then LW 0x10 -> 0x80F1A2B3.
  - LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80F1; LHU 0x10 -> 0x0000A2B3.
- Partial store preservation: after the above, SB 0x55 at 0x11, then LW 0x10 -> 0x80F155B3; SH 0x1234 at 0x12, then LW 0x10 -> 0x123455B3.
- Misaligned: SW 0xDEADBEEF at 0x22 -> Misaligned=1 and word 0x20 unchanged (LW -> 0); LH 0x21 -> Misaligned=1, DataMemRead=0; LB 0x21 -> Misaligned=0.
- Faults:
  - DEPTH_WORDS=256: SW 0xFFFFFFFF at 0x400 -> AccessFault=1, and LW 0x000 is still 0.
  - Load with Funct3=011 -> AccessFault=1, DataMemRead=0.
  - MemRead=MemWrite=0 with Address=0x400 -> AccessFault=0.
- Read-during-write and reset mid-operation:
  - Word 0x30 = 0x11111111; SW 0x22222222 with MemRead=1 -> DataMemRead=0x11111111 before the edge, 0x22222222 after.
  - Assert rst_n=0 mid-cycle during a pending SW -> no write occurs and a subsequent LW returns 0.
